decode_hazard_scoreboard: RTL and testbench

Issue controller for the decode stage of the RISC-V pipeline. It keeps a per-register scoreboard of in-flight writes and stalls decode on RAW/WAW hazards against registers that are still pending. Writeback clears the pending bits, and a flush squashes all in-flight writers and blocks issue during a drain window. The block sits beside the decoder, between the fetch/decode hand-off and the register-file read ports.

---
 rtl/decode_hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_decode_hazard_scoreboard.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage issue controller: per-register pending-write scoreboard with RAW/WAW stall,
// flush drain window and stall counter. Define DECODE_HAZARD_WB_BYPASS_EN to let a same-cycle writeback release a stall.
module decode_hazard_scoreboard #(
    parameter int DRAIN_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid,
    input  logic [4:0]             dec_rs1,
    input  logic [4:0]             dec_rs2,
    input  logic [4:0]             dec_rd,
    input  logic                   dec_uses_rs1,
    input  logic                   dec_uses_rs2,
    input  logic                   dec_writes_rd,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic                   flush,
    output logic                   issue,
    output logic                   dec_stall,
    output logic [31:0]            busy_mask,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   wb_spurious
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [31:0]            busy_q, busy_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   spur_q, spur_d;

    logic        wb_live;
    logic [31:0] wb_onehot;
    logic [31:0] pend;
    logic        hazard;

    // Writebacks arriving while draining belong to squashed instructions.
    assign wb_live   = wb_valid & (state_q != DRAIN);
    assign wb_onehot = wb_live ? (32'd1 << wb_rd) : 32'd0;

`ifdef DECODE_HAZARD_WB_BYPASS_EN
    assign pend = busy_q & ~wb_onehot;
`else
    assign pend = busy_q;
`endif

    assign hazard    = dec_valid & ((dec_uses_rs1 & pend[dec_rs1]) |
                                    (dec_uses_rs2 & pend[dec_rs2]) |
                                    (dec_writes_rd & pend[dec_rd]));
    assign issue     = dec_valid & ~hazard & ~flush & (state_q != DRAIN);
    assign dec_stall = dec_valid & ~issue;

    always_comb begin
        busy_d = busy_q & ~wb_onehot;
        if (issue && dec_writes_rd && (dec_rd != 5'd0)) begin
            busy_d[dec_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = 32'd0;
        end
        busy_d[0] = 1'b0;

        spur_d = spur_q | (wb_live & (wb_rd != 5'd0) & ~busy_q[wb_rd]);

        stall_cnt_d = stall_cnt_q;
        if (dec_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q      <= 32'd0;
            stall_cnt_q <= '0;
            spur_q      <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            spur_q      <= spur_d;
        end
    end

    // Flush from any state (re)loads the drain counter so DRAIN spans DRAIN_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= DRAIN;
            cnt_q   <= CNT_W'(DRAIN_CYCLES - 1);
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dec_stall) state_q <= STALL;
                end
                STALL: begin
                    if (!hazard) state_q <= RUN;
                end
                DRAIN: begin
                    if (cnt_q == '0) state_q <= RUN;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign busy_mask   = busy_q;
    assign state       = state_q;
    assign stall_count = stall_cnt_q;
    assign wb_spurious = spur_q;

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Bench for decode_hazard_scoreboard: directed checks from the test plan plus randomized traffic
// compared every cycle against a behavioural scoreboard model.
module tb_decode_hazard_scoreboard;

    localparam int DRAIN_CYCLES = 2;
    localparam int STALL_CNT_W  = 16;
    localparam longint MAXC     = (64'd1 << STALL_CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   dec_valid = 1'b0;
    logic [4:0]             dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic                   dec_uses_rs1 = 1'b0, dec_uses_rs2 = 1'b0, dec_writes_rd = 1'b0;
    logic                   wb_valid = 1'b0;
    logic [4:0]             wb_rd = '0;
    logic                   flush = 1'b0;
    logic                   issue, dec_stall, wb_spurious;
    logic [31:0]            busy_mask;
    logic [1:0]             state;
    logic [STALL_CNT_W-1:0] stall_count;

    int compared   = 0;
    int mismatched = 0;

    decode_hazard_scoreboard #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .dec_uses_rs1 (dec_uses_rs1),
        .dec_uses_rs2 (dec_uses_rs2),
        .dec_writes_rd(dec_writes_rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .issue        (issue),
        .dec_stall    (dec_stall),
        .busy_mask    (busy_mask),
        .state        (state),
        .stall_count  (stall_count),
        .wb_spurious  (wb_spurious)
    );

    always #5 clk = ~clk;

    // Reference model: a set of pending registers, a mode (0 run, 1 stall, 2 drain) and counters.
    bit     mValid = 1'b0;
    bit     mBusy[32];
    int     mState = 0;
    int     mCnt   = 0;
    longint mStall = 0;
    bit     mSpur  = 1'b0;

    function automatic bit mPending(input logic [4:0] r);
        bit p;
        p = (r != 5'd0) && mBusy[r];
`ifdef DECODE_HAZARD_WB_BYPASS_EN
        if (wb_valid && mState != 2 && wb_rd == r) p = 1'b0;
`endif
        return p;
    endfunction

    function automatic bit mHazard();
        return dec_valid && ((dec_uses_rs1 && mPending(dec_rs1)) ||
                             (dec_uses_rs2 && mPending(dec_rs2)) ||
                             (dec_writes_rd && mPending(dec_rd)));
    endfunction

    function automatic bit mIssue();
        return dec_valid && !mHazard() && !flush && mState != 2;
    endfunction

    function automatic logic [31:0] mMask();
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) m[i] = mBusy[i];
        return m;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
            mState = 0;
            mCnt   = 0;
            mStall = 0;
            mSpur  = 1'b0;
            mValid = 1'b1;
        end else if (mValid) begin
            bit h, iss;
            h   = mHazard();
            iss = mIssue();
            if (wb_valid && mState != 2 && wb_rd != 5'd0) begin
                if (!mBusy[wb_rd]) mSpur = 1'b1;
                mBusy[wb_rd] = 1'b0;
            end
            if (iss && dec_writes_rd && dec_rd != 5'd0) mBusy[dec_rd] = 1'b1;
            if (dec_valid && !iss && mStall < MAXC) mStall++;
            if (flush) begin
                for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
                mState = 2;
                mCnt   = DRAIN_CYCLES - 1;
            end else if (mState == 2) begin
                if (mCnt == 0) mState = 0;
                else           mCnt--;
            end else begin
                mState = h ? 1 : 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mValid) begin
            bit iss;
            iss = mIssue();
            checkOutput("model.issue", 64'(issue), 64'(iss));
            checkOutput("model.dec_stall", 64'(dec_stall), 64'(dec_valid && !iss));
            checkOutput("model.busy_mask", 64'(busy_mask), 64'(mMask()));
            checkOutput("model.state", 64'(state), 64'(mState));
            checkOutput("model.stall_count", 64'(stall_count), 64'(mStall));
            checkOutput("model.wb_spurious", 64'(wb_spurious), 64'(mSpur));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_uses_rs1 = 1'b0; dec_uses_rs2 = 1'b0; dec_writes_rd = 1'b0;
        wb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic [4:0] rd, input logic w);
        dec_valid = v; dec_rs1 = rs1; dec_uses_rs1 = u1; dec_rs2 = rs2; dec_uses_rs2 = u2;
        dec_rd = rd; dec_writes_rd = w;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        cyc(); cyc();
        rst = 1'b1;
        #2;
        checkOutput("reset.busy", 64'(busy_mask), 64'h0);
        checkOutput("reset.state", 64'(state), 64'd0);
        checkOutput("reset.stall_count", 64'(stall_count), 64'd0);
        checkOutput("reset.spurious", 64'(wb_spurious), 64'd0);

        // add x5
        applyStimulus(1, 0, 0, 0, 0, 5, 1);
        #2 checkOutput("add.issue", 64'(issue), 64'd1);
        cyc(); idle();
        #2 checkOutput("add.busy", 64'(busy_mask), 64'h20);
        checkOutput("add.stall_count", 64'(stall_count), 64'd0);
        cyc();

        // sub x6, x5 held three cycles
        applyStimulus(1, 5, 1, 0, 0, 6, 1);
        for (int k = 0; k < 3; k++) begin
            #2 checkOutput("raw.dec_stall", 64'(dec_stall), 64'd1);
            if (k > 0) checkOutput("raw.state", 64'(state), 64'd1);
            cyc();
        end
        #2 checkOutput("raw.stall_count", 64'(stall_count), 64'd3);
        wb_valid = 1'b1; wb_rd = 5'd5;
`ifdef DECODE_HAZARD_WB_BYPASS_EN
        #1 checkOutput("raw.bypass_issue", 64'(issue), 64'd1);
        cyc(); idle();
        #2 checkOutput("raw.stall_after", 64'(stall_count), 64'd3);
`else
        #1 checkOutput("raw.wb_cycle_issue", 64'(issue), 64'd0);
        cyc(); wb_valid = 1'b0;
        #2 checkOutput("raw.next_issue", 64'(issue), 64'd1);
        cyc(); idle();
        #2 checkOutput("raw.stall_after", 64'(stall_count), 64'd4);
`endif
        checkOutput("raw.busy", 64'(busy_mask), 64'h40);
        cyc();

        // x7 busy, then re-issue rd=7 alongside wb x7
        applyStimulus(1, 0, 0, 0, 0, 7, 1);
        cyc(); idle();
        #2 checkOutput("waw.busy", 64'(busy_mask), 64'hC0);
        applyStimulus(1, 0, 0, 0, 0, 7, 1);
        wb_valid = 1'b1; wb_rd = 5'd7;
`ifdef DECODE_HAZARD_WB_BYPASS_EN
        #1 checkOutput("waw.bypass_issue", 64'(issue), 64'd1);
        cyc(); idle();
`else
        #1 checkOutput("waw.wb_cycle_issue", 64'(issue), 64'd0);
        cyc(); wb_valid = 1'b0;
        #2 checkOutput("waw.next_issue", 64'(issue), 64'd1);
        cyc(); idle();
`endif
        #2 checkOutput("waw.busy7", 64'(busy_mask[7]), 64'd1);
        checkOutput("waw.spurious", 64'(wb_spurious), 64'd0);
        cyc();

        // x0 writes and writebacks
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        #2 checkOutput("x0.issue", 64'(issue), 64'd1);
        cyc(); idle();
        #2 checkOutput("x0.busy", 64'(busy_mask), 64'hC0);
        wb_valid = 1'b1; wb_rd = 5'd0;
        cyc(); idle();
        #2 checkOutput("x0.wb_busy", 64'(busy_mask), 64'hC0);
        checkOutput("x0.spurious", 64'(wb_spurious), 64'd0);

        // move to busy_mask = 0x60
        wb_valid = 1'b1; wb_rd = 5'd7;
        cyc(); idle();
        applyStimulus(1, 0, 0, 0, 0, 5, 1);
        cyc(); idle();
        #2 checkOutput("pre_flush.busy", 64'(busy_mask), 64'h60);

        // flush with a valid instruction writing x8
        applyStimulus(1, 0, 0, 0, 0, 8, 1);
        flush = 1'b1;
        #1 checkOutput("flush.issue", 64'(issue), 64'd0);
        cyc(); flush = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd5;
        #2 checkOutput("drain1.busy", 64'(busy_mask), 64'h0);
        checkOutput("drain1.state", 64'(state), 64'd2);
        checkOutput("drain1.issue", 64'(issue), 64'd0);
        cyc(); wb_valid = 1'b0;
        #2 checkOutput("drain2.state", 64'(state), 64'd2);
        checkOutput("drain2.issue", 64'(issue), 64'd0);
        cyc();
        #2 checkOutput("run.state", 64'(state), 64'd0);
        checkOutput("run.issue", 64'(issue), 64'd1);
        checkOutput("run.spurious", 64'(wb_spurious), 64'd0);
        cyc(); idle();
        #2 checkOutput("run.busy", 64'(busy_mask), 64'h100);

        // saturate the stall counter on a RAW against x8
        applyStimulus(1, 8, 1, 0, 0, 0, 0);
        for (int k = 0; k < 70000; k++) cyc();
        idle();
        #2 checkOutput("sat.stall_count", 64'(stall_count), 64'hFFFF);

        // spurious writeback to x9
        wb_valid = 1'b1; wb_rd = 5'd9;
        cyc(); idle();
        #2 checkOutput("spur.set", 64'(wb_spurious), 64'd1);
        for (int k = 0; k < 5; k++) cyc();
        checkOutput("spur.sticky", 64'(wb_spurious), 64'd1);

        // randomized traffic with occasional flush and reset
        for (int k = 0; k < 4000; k++) begin
            rst           = ($urandom_range(0, 299) != 0);
            dec_valid     = ($urandom_range(0, 3) != 0);
            dec_rs1       = 5'($urandom_range(0, 7));
            dec_rs2       = 5'($urandom_range(0, 7));
            dec_rd        = 5'($urandom_range(0, 7));
            dec_uses_rs1  = 1'($urandom_range(0, 1));
            dec_uses_rs2  = 1'($urandom_range(0, 1));
            dec_writes_rd = 1'($urandom_range(0, 1));
            wb_valid      = ($urandom_range(0, 2) == 0);
            wb_rd         = 5'($urandom_range(0, 7));
            flush         = ($urandom_range(0, 39) == 0);
            cyc();
        end

        idle();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        #2 checkOutput("final.busy", 64'(busy_mask), 64'h0);
        checkOutput("final.state", 64'(state), 64'd0);
        checkOutput("final.spurious", 64'(wb_spurious), 64'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
